// File: rtl/sbus_pkg.sv
// Shared S.BUS constants, frame flag positions and the byte bit-reverse helper.
// Used by both the transmit framer and the receive path.
package sbus_pkg;

  localparam int unsigned SBUS_FRAME_BYTES  = 25;
  localparam int unsigned SBUS_FRAME_BITS   = 200;
  localparam int unsigned SBUS_NUM_CH       = 16;
  localparam int unsigned SBUS_CH_BITS      = 11;
  localparam int unsigned SBUS_CH_DATA_BITS = SBUS_NUM_CH * SBUS_CH_BITS;

  localparam logic [7:0]  SBUS_HDR       = 8'h0F;
  localparam logic [7:0]  SBUS_FTR       = 8'h00;
  localparam logic [10:0] SBUS_CH_CENTER = 11'd992;

  // Bit positions inside the standard (un-reversed) flag byte s[23]
  localparam int unsigned SBUS_FLAG_CH17     = 0;
  localparam int unsigned SBUS_FLAG_CH18     = 1;
  localparam int unsigned SBUS_FLAG_LOST     = 2;
  localparam int unsigned SBUS_FLAG_FAILSAFE = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend
  } sbus_tx_state_e;

  function automatic logic [7:0] sbus_bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sbus_frame_timer.sv
// Free-running frame period counter with a one-cycle tick on the last count.
// Held at zero while enable is low.
module sbus_frame_timer #(
  parameter int unsigned PERIOD_CYCLES = 700000
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PERIOD_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tick = enable && (count_q == CntLast);

  always_comb begin
    count_d = count_q;
    if (!enable || tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sbus_encoder.sv
// S.BUS transmit framer: shadows the channels, builds a 25-byte frame once per
// period and streams it over a valid/ready byte handshake. SBUS_FAILSAFE_EN adds the lost/failsafe counter.
module sbus_encoder
  import sbus_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned FRAME_PERIOD_US = 14000,
  parameter int unsigned FAILSAFE_FRAMES = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic [SBUS_CH_DATA_BITS-1:0] ch_data,
  input  logic [1:0]                   ch_dig,
  input  logic                         ch_load,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         frame_start,
  output logic                         frame_done,
  output logic                         frame_overrun,
  output logic [SBUS_FRAME_BITS-1:0]   sbus_frame
);

  localparam int unsigned PERIOD_CYCLES = CLK_HZ / 1000000 * FRAME_PERIOD_US;
  localparam logic [4:0]  LastIdx       = 5'(SBUS_FRAME_BYTES - 1);

  sbus_tx_state_e              state_q, state_d;
  logic [4:0]                  idx_q, idx_d;
  logic [SBUS_FRAME_BITS-1:0]  frame_q, frame_d, frame_next;
  logic [SBUS_CH_DATA_BITS-1:0] shadow_ch_q;
  logic [1:0]                  shadow_dig_q;
  logic                        done_q, done_d;
  logic                        overrun_q;
  logic                        tick;
  logic                        frame_lost, failsafe;
  logic [7:0]                  flags;

  sbus_frame_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_timer (
    .clk   (clk),
    .resetn(resetn),
    .enable(enable),
    .tick  (tick)
  );

  // Shadow loads regardless of FSM state; a concurrent LOAD sees the old value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_ch_q  <= {SBUS_NUM_CH{SBUS_CH_CENTER}};
      shadow_dig_q <= '0;
    end else if (ch_load) begin
      shadow_ch_q  <= ch_data;
      shadow_dig_q <= ch_dig;
    end
  end

`ifdef SBUS_FAILSAFE_EN
  logic [2:0] lost_cnt_q, lost_cnt_d;

  always_comb begin
    lost_cnt_d = lost_cnt_q;
    if (ch_load) begin
      lost_cnt_d = '0;
    end else if (state_q == StLoad && lost_cnt_q != 3'd7) begin
      lost_cnt_d = lost_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lost_cnt_q <= '0;
    end else begin
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign frame_lost = ({29'd0, lost_cnt_q} >= FAILSAFE_FRAMES);
  assign failsafe   = ({29'd0, lost_cnt_q} >= 2 * FAILSAFE_FRAMES);
`else
  assign frame_lost = 1'b0;
  assign failsafe   = 1'b0;
`endif

  // Whole frame is stored already bit-reversed, i.e. in wire order.
  always_comb begin
    flags                     = '0;
    flags[SBUS_FLAG_CH17]     = shadow_dig_q[0];
    flags[SBUS_FLAG_CH18]     = shadow_dig_q[1];
    flags[SBUS_FLAG_LOST]     = frame_lost;
    flags[SBUS_FLAG_FAILSAFE] = failsafe;
    frame_next                = '0;
    frame_next[7:0]           = sbus_bitrev8(SBUS_HDR);
    for (int b = 1; b <= 22; b++) begin
      frame_next[8*b +: 8] = sbus_bitrev8(shadow_ch_q[8*(b-1) +: 8]);
    end
    frame_next[8*23 +: 8] = sbus_bitrev8(flags);
    frame_next[8*24 +: 8] = sbus_bitrev8(SBUS_FTR);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        frame_d = frame_next;
        idx_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (tx_ready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      frame_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      overrun_q <= tick && busy;
    end
  end

  assign busy          = (state_q != StIdle);
  assign tx_valid      = (state_q == StSend);
  assign tx_data       = tx_valid ? frame_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign frame_start   = (state_q == StLoad);
  assign frame_done    = done_q;
  assign frame_overrun = overrun_q;
  assign sbus_frame    = frame_q;

endmodule
